// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing two interval timers between a CPU data port (m0) and a
// debug/loader port (m1); also registers timer IRQs onto the CPU hardware-interrupt vector.
module timer_bus_arbiter #(
  parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10,
  parameter logic [31:0] MISS_DATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_ready,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_ready,
  output logic [31:0] o_m1_rdata,
  output logic [1:0]  o_t0_addr,
  output logic        o_t0_we,
  output logic [31:0] o_t0_wdata,
  input  logic [31:0] i_t0_rdata,
  input  logic        i_t0_irq,
  output logic [1:0]  o_t1_addr,
  output logic        o_t1_we,
  output logic [31:0] o_t1_wdata,
  input  logic [31:0] i_t1_rdata,
  input  logic        i_t1_irq,
  output logic [5:0]  o_hwint
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      r_state;
  logic [31:0] r_cmd_addr;
  logic        r_cmd_we;
  logic [31:0] r_cmd_wdata;
  logic        r_cmd_owner;
  logic        r_last_owner;
  logic [31:0] r_rdata;
  logic [5:0]  r_hwint;
  logic        r_t0_we;
  logic        r_t1_we;
  logic        r_m0_ready;
  logic        r_m1_ready;

  logic        w_any_req;
  logic        w_grant_m1;
  logic [31:0] w_sel_addr;
  logic        w_sel_we;
  logic [31:0] w_sel_wdata;
  logic        w_sel_hit0;
  logic        w_sel_hit1;
  logic        w_hit0;
  logic        w_hit1;

  // m1 wins when alone, or on a tie when m0 was served last.
  assign w_any_req  = i_m0_req | i_m1_req;
  assign w_grant_m1 = i_m1_req & (~i_m0_req | ~r_last_owner);

  assign w_sel_addr  = w_grant_m1 ? i_m1_addr  : i_m0_addr;
  assign w_sel_we    = w_grant_m1 ? i_m1_we    : i_m0_we;
  assign w_sel_wdata = w_grant_m1 ? i_m1_wdata : i_m0_wdata;

  // Timer 0 takes priority if the two windows overlap.
  assign w_sel_hit0 = (w_sel_addr[31:4] == TIMER0_BASE[31:4]);
  assign w_sel_hit1 = ~w_sel_hit0 & (w_sel_addr[31:4] == TIMER1_BASE[31:4]);
  assign w_hit0     = (r_cmd_addr[31:4] == TIMER0_BASE[31:4]);
  assign w_hit1     = ~w_hit0 & (r_cmd_addr[31:4] == TIMER1_BASE[31:4]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cmd_addr   <= '0;
      r_cmd_we     <= 1'b0;
      r_cmd_wdata  <= '0;
      r_cmd_owner  <= 1'b0;
      r_last_owner <= 1'b1;
      r_rdata      <= '0;
      r_hwint      <= '0;
      r_t0_we      <= 1'b0;
      r_t1_we      <= 1'b0;
      r_m0_ready   <= 1'b0;
      r_m1_ready   <= 1'b0;
    end else begin
      r_hwint    <= {4'b0000, i_t1_irq, i_t0_irq};
      r_t0_we    <= 1'b0;
      r_t1_we    <= 1'b0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_cmd_addr  <= w_sel_addr;
            r_cmd_we    <= w_sel_we;
            r_cmd_wdata <= w_sel_wdata;
            r_cmd_owner <= w_grant_m1;
            // Strobes are registered here so they are high exactly during ACCESS.
            r_t0_we     <= w_sel_we & w_sel_hit0;
            r_t1_we     <= w_sel_we & w_sel_hit1;
            r_state     <= StAccess;
          end
        end
        StAccess: begin
          r_rdata    <= w_hit0 ? i_t0_rdata : (w_hit1 ? i_t1_rdata : MISS_DATA);
          r_m0_ready <= ~r_cmd_owner;
          r_m1_ready <= r_cmd_owner;
          r_state    <= StResp;
        end
        StResp: begin
          r_last_owner <= r_cmd_owner;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_t0_addr  = r_cmd_addr[3:2];
  assign o_t1_addr  = r_cmd_addr[3:2];
  assign o_t0_wdata = r_cmd_wdata;
  assign o_t1_wdata = r_cmd_wdata;
  assign o_t0_we    = r_t0_we;
  assign o_t1_we    = r_t1_we;
  assign o_m0_ready = r_m0_ready;
  assign o_m1_ready = r_m1_ready;
  assign o_m0_rdata = r_rdata;
  assign o_m1_rdata = r_rdata;
  assign o_hwint    = r_hwint;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Directed bench for timer_bus_arbiter: writes, reads, misses, round-robin ties,
// mid-transaction reset and IRQ registering, all against hand-computed expectations.
module tb_timer_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  t0_addr, t1_addr;
  logic        t0_we, t1_we;
  logic [31:0] t0_wdata, t1_wdata, t0_rdata, t1_rdata;
  logic        t0_irq, t1_irq;
  logic [5:0]  hwint;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  timer_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .i_m0_req   (m0_req),
    .i_m0_addr  (m0_addr),
    .i_m0_we    (m0_we),
    .i_m0_wdata (m0_wdata),
    .o_m0_ready (m0_ready),
    .o_m0_rdata (m0_rdata),
    .i_m1_req   (m1_req),
    .i_m1_addr  (m1_addr),
    .i_m1_we    (m1_we),
    .i_m1_wdata (m1_wdata),
    .o_m1_ready (m1_ready),
    .o_m1_rdata (m1_rdata),
    .o_t0_addr  (t0_addr),
    .o_t0_we    (t0_we),
    .o_t0_wdata (t0_wdata),
    .i_t0_rdata (t0_rdata),
    .i_t0_irq   (t0_irq),
    .o_t1_addr  (t1_addr),
    .o_t1_we    (t1_we),
    .o_t1_wdata (t1_wdata),
    .i_t1_rdata (t1_rdata),
    .i_t1_irq   (t1_irq),
    .o_hwint    (hwint)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    t0_rdata = '0; t1_rdata = '0; t0_irq = 0; t1_irq = 0;
    tick();
    tick();
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_t0_we", t0_we, 0);
    check("rst_t1_we", t1_we, 0);
    check("rst_rdata", m0_rdata, 0);
    check("rst_hwint", hwint, 0);
    reset = 1'b0;

    // m0 write to timer 0 word 1
    m0_req = 1; m0_we = 1; m0_addr = 32'h7F04; m0_wdata = 32'h10;
    tick();
    check("wr_t0_we", t0_we, 1);
    check("wr_t0_addr", t0_addr, 1);
    check("wr_t0_wdata", t0_wdata, 32'h10);
    check("wr_t1_we", t1_we, 0);
    check("wr_m0_ready_early", m0_ready, 0);
    m0_addr = 32'h7F1C; m0_wdata = 32'hFFFF;  // ignored: command already latched
    tick();
    check("wr_m0_ready", m0_ready, 1);
    check("wr_m1_ready", m1_ready, 0);
    check("wr_t0_we_once", t0_we, 0);
    m0_req = 0;
    tick();
    check("wr_m0_ready_drop", m0_ready, 0);

    // m1 read of timer 1 word 2
    t1_rdata = 32'h5;
    m1_req = 1; m1_we = 0; m1_addr = 32'h7F18;
    tick();
    check("rd_t1_we", t1_we, 0);
    check("rd_t0_we", t0_we, 0);
    check("rd_t1_addr", t1_addr, 2);
    tick();
    check("rd_m1_ready", m1_ready, 1);
    check("rd_m0_ready", m0_ready, 0);
    check("rd_m1_rdata", m1_rdata, 32'h5);
    m1_req = 0; t1_rdata = 32'hBEEF;
    tick();
    check("rd_m1_ready_drop", m1_ready, 0);
    check("rd_m1_rdata_hold", m1_rdata, 32'h5);

    // Both requesting from reset: m0,m1,m0,m1, one ready every 3 cycles
    reset = 1;
    tick();
    reset = 0;
    t0_rdata = 32'hDEAD;
    m0_req = 1; m0_we = 1; m0_addr = 32'h7F00; m0_wdata = 32'hA;
    m1_req = 1; m1_we = 1; m1_addr = 32'h7F14; m1_wdata = 32'hB;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr%0d_t0_we", i), t0_we, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_t1_we", i), t1_we, (i % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("rr%0d_m0_ready", i), m0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_m1_ready", i), m1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("rr%0d_idle_ready", i), {m0_ready, m1_ready}, 0);
    end
    m0_req = 0; m1_req = 0;
    check("rr_rdata_t1", m1_rdata, 32'hBEEF);

    // Miss: write then read outside both windows
    m0_req = 1; m0_we = 1; m0_addr = 32'h1000; m0_wdata = 32'h77;
    tick();
    check("miss_wr_we", {t0_we, t1_we}, 0);
    tick();
    check("miss_wr_ready", m0_ready, 1);
    check("miss_wr_rdata", m0_rdata, 32'h0);
    m0_req = 0;
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 32'h7F08;  // refill rdata with 0xDEAD
    tick();
    tick();
    check("hit_rd_rdata", m1_rdata, 32'hDEAD);
    m1_req = 0;
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000;
    tick();
    check("miss_rd_we", {t0_we, t1_we}, 0);
    tick();
    check("miss_rd_ready", m0_ready, 1);
    check("miss_rd_rdata", m0_rdata, 32'h0);
    m0_req = 0;
    tick();

    // Reset during ACCESS of an m1 write
    m1_req = 1; m1_we = 1; m1_addr = 32'h7F00; m1_wdata = 32'h55;
    tick();
    check("rstacc_t0_we", t0_we, 1);
    reset = 1;
    tick();
    check("rstacc_m1_ready", m1_ready, 0);
    check("rstacc_t0_we_clr", t0_we, 0);
    tick();
    check("rstacc_hold_we", {t0_we, t1_we}, 0);
    check("rstacc_hold_ready", {m0_ready, m1_ready}, 0);
    reset = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'h7F08; m0_wdata = 32'h99;
    tick();
    check("rstacc_grant_addr", t0_addr, 2);
    check("rstacc_grant_wdata", t0_wdata, 32'h99);
    tick();
    check("rstacc_m0_ready", m0_ready, 1);
    check("rstacc_m1_ready2", m1_ready, 0);
    m0_req = 0; m1_req = 0;
    tick();

    // IRQ registering
    t0_irq = 1;
    tick();
    check("irq_k1", hwint, 6'b000001);
    tick();
    tick();
    check("irq_k3", hwint, 6'b000001);
    t1_irq = 1;
    tick();
    check("irq_k4", hwint, 6'b000011);
    t0_irq = 0; t1_irq = 0;
    check("irq_still", hwint, 6'b000011);
    tick();
    check("irq_clear", hwint, 6'b000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_bus_arbiter.md
Name: timer_bus_arbiter

Overview:
- Shares the two on-chip interval timers between two bus masters: m0 (CPU data port) and m1 (debug/loader port).
- Arbitrates requests round-robin and latches the winner's command.
- Decodes the address to one of two 16-byte timer windows and drives that timer's word-select/WE/data for exactly one cycle.
- Returns registered read data with a one-cycle ready pulse, and registers timer IRQs onto the CPU hardware-interrupt vector.

Parameters:
- TIMER0_BASE, 32'h0000_7F00, byte base of timer 0 window (addr[31:4] compared)
- TIMER1_BASE, 32'h0000_7F10, byte base of timer 1 window (addr[31:4] compared)
- MISS_DATA, 32'h0000_0000, read data returned for an address hitting no window

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- m0_req  in  1  master 0 request, held until m0_ready
- m0_addr  in  32  master 0 byte address
- m0_we  in  1  master 0 write (1) / read (0)
- m0_wdata  in  32  master 0 write data
- m0_ready  out  1  one-cycle completion pulse to master 0
- m0_rdata  out  32  read data, valid when m0_ready
- m1_req, m1_addr, m1_we, m1_wdata, m1_ready, m1_rdata  same as m0_* for master 1
- t0_addr  out  2  timer 0 word select (cmd addr[3:2])
- t0_we  out  1  timer 0 write strobe
- t0_wdata  out  32  timer 0 write data
- t0_rdata  in  32  timer 0 read data (combinational from timer)
- t0_irq  in  1  timer 0 interrupt
- t1_addr, t1_we, t1_wdata, t1_rdata, t1_irq  same for timer 1
- hwint  out  6  CPU hardware interrupt lines

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Registers: cmd_addr, cmd_we, cmd_wdata, cmd_owner, last_owner (rr pointer), rdata_q, hwint_q.
- Reset: state=IDLE; last_owner=1, so m0 wins the first tie; cmd_* =0; rdata_q=0; hwint_q=0. All outputs read 0: m*_ready=0, t*_we=0, m*_rdata=0, hwint=0.
- IDLE:
  - No req: stay.
  - One req: grant that master.
  - Both req: grant the master != last_owner.
  - On grant: latch the winner's addr/we/wdata and cmd_owner; go to ACCESS.
- ACCESS:
  - Decode: hit0 = cmd_addr[31:4]==TIMER0_BASE[31:4]; hit1 likewise; TIMER0 has priority if the bases overlap.
  - t0_addr/t1_addr = cmd_addr[3:2] at all times. t*_wdata = cmd_wdata at all times.
  - t0_we = cmd_we & hit0 only in ACCESS (same for t1). WE is high exactly one cycle per write.
  - rdata_q <= t0_rdata if hit0, t1_rdata if hit1, else MISS_DATA. Captured for writes too; the value is don't-care to the master.
  - Next state RESP.
- RESP:
  - m<cmd_owner>_ready=1 for this cycle only; the other master's ready stays 0.
  - last_owner<=cmd_owner; next state IDLE.
- m0_rdata = m1_rdata = rdata_q; both hold their value until the next capture.
- Latency: req sampled in IDLE at cycle n gives t*_we in cycle n+1 and ready in cycle n+2. Throughput is one transaction per 3 cycles.
- A req still high in RESP is not a new request. Re-arbitration happens only in IDLE, so a master holding req across ready is serviced again no earlier than 3 cycles later.
- A master dropping req after the grant: the transaction still completes and ready still pulses. Deasserting before ready is a protocol violation but must not hang the FSM.
- Miss: no t*_we asserted; rdata=MISS_DATA; ready still issued.
- Inputs changing during ACCESS/RESP have no effect; the command is fully latched.
- Interrupts: hwint_q <= {4'b0, t1_irq, t0_irq} every cycle, giving a one-cycle registered delay. This is independent of the bus FSM.
- Reset mid-transaction: the FSM aborts to IDLE next edge. No ready pulse and no t*_we are issued after reset is asserted, since reset is sampled first.

Test Plan:
- m0 writes addr 0x7F04, wdata 0x10 -> next cycle t0_we=1, t0_addr=2'b01, t0_wdata=0x10; t1_we=0; m0_ready=1 one cycle later; m1_ready=0.
- m1 reads addr 0x7F18 while t1_rdata=0x0000_0005 -> t1_we stays 0; m1_ready pulses 2 cycles after req; m1_rdata=0x5 and held after ready falls.
- m0_req and m1_req both held high from reset -> grants alternate m0,m1,m0,m1. Ready pulses every 3 cycles, never both in the same cycle.
- m0 reads 0x0000_1000 (miss) -> no t0_we/t1_we; m0_ready after 2 cycles; m0_rdata=0x0000_0000.
- Reset asserted during ACCESS of an m1 write to 0x7F00 -> no m1_ready. Reset during IDLE/RESP gives no t*_we. After release, the next simultaneous request is granted to m0.
- t0_irq high at cycle k, t1_irq high at k+3 -> hwint=6'b000001 from k+1, 6'b000011 from k+4; hwint=0 one cycle after both drop.
